// File: rtl/port_endpoint.sv
// -----------------------------------------------------------------------------
// port_endpoint
//
// Node-side endpoint for one port of the topology connector. It turns the
// router core's local valid/ready streams into the registered link bundle:
//   - TX: a single output register feeds link_valid + packet.
//   - RX: an inbound FIFO that advertises space through a registered
//     link_ready.
// Every bit of port_o is a flop output.
//
// Ports
//   clk, rst   clock, synchronous active-high reset
//   port_o     outbound bundle {link_valid, link_ready, packet}
//   port_i     inbound bundle from the peer, same layout
//   tx_data    local packet to send
//   tx_valid   local packet present
//   tx_ready   local packet accepted this cycle
//   rx_data    head of the receive FIFO (first-word fall-through)
//   rx_valid   receive FIFO non-empty
//   rx_ready   local consumer pops the head this cycle
//   tx_count   accepted link transfers out, 16-bit saturating (LINK_STATS_EN only)
//   rx_count   FIFO writes from the link, 16-bit saturating (LINK_STATS_EN only)
//
// Build option
//   LINK_STATS_EN  when defined, adds the tx_count/rx_count ports and counters.
// -----------------------------------------------------------------------------
module port_endpoint #(
  parameter int PORT_SIZE  = 39,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PORT_SIZE-1:0] port_o,
  input  logic [PORT_SIZE-1:0] port_i,
  input  logic [PORT_SIZE-3:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [PORT_SIZE-3:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready
`ifdef LINK_STATS_EN
  ,
  output logic [15:0]          tx_count,
  output logic [15:0]          rx_count
`endif
);

  localparam int DATA_SIZE = PORT_SIZE - 2;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic                 peer_valid;
  logic                 peer_ready;
  logic                 acc;
  logic                 wr_en;
  logic                 rd_en;

  logic                 out_valid_q, out_valid_d;
  logic [DATA_SIZE-1:0] out_data_q,  out_data_d;
  logic                 link_ready_q, link_ready_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];

  // ---- TX stage: output register toward the link ----
  always_comb begin
    peer_valid  = port_i[PORT_SIZE-1];
    peer_ready  = port_i[PORT_SIZE-2];
    acc         = out_valid_q & peer_ready;
    // During reset the register is being cleared anyway, so only the
    // peer's ready is reported.
    tx_ready    = rst ? peer_ready : (~out_valid_q | peer_ready);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (tx_valid && tx_ready) begin
      out_valid_d = 1'b1;
      out_data_d  = tx_data;
    end else if (acc) begin
      out_valid_d = 1'b0;
    end
  end

  // ---- RX stage: inbound FIFO and registered link_ready ----
  always_comb begin
    rx_valid = (count_q != '0);
    rx_data  = mem[rd_ptr_q];
    // Inbound valid while we were not ready is dropped silently.
    wr_en    = peer_valid & link_ready_q;
    rd_en    = rx_valid & rx_ready;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    // Ready is based on the post-edge occupancy, so a sender that sees it
    // high can always place one packet without overflowing.
    link_ready_d = (count_d < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      link_ready_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      link_ready_q <= link_ready_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage holds no control state, so it is left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= port_i[DATA_SIZE-1:0];
    end
  end

  assign port_o = {out_valid_q, link_ready_q, out_data_q};

`ifdef LINK_STATS_EN
  // ---- Link statistics ----
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    tx_cnt_d = sat_inc(tx_cnt_q, acc);
    rx_cnt_d = sat_inc(rx_cnt_q, wr_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign tx_count = tx_cnt_q;
  assign rx_count = rx_cnt_q;
`endif

endmodule

// File: tb/tb_port_endpoint.sv
// -----------------------------------------------------------------------------
// tb_port_endpoint
//
// Directed bench for port_endpoint. The bench acts as the link peer through
// peer_o, or loops port_o straight back into port_i. Inputs change 1 time
// unit after a rising edge and outputs are sampled at that point, i.e. they
// show the state after the edge just taken.
// -----------------------------------------------------------------------------
module tb_port_endpoint;

  localparam int PS = 39;
  localparam int DS = PS - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [PS-1:0] port_o;
  logic [PS-1:0] port_i;
  logic [PS-1:0] peer_o;
  logic          loopback;
  logic [DS-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DS-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
`ifdef LINK_STATS_EN
  logic [15:0]   tx_count;
  logic [15:0]   rx_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign port_i = loopback ? port_o : peer_o;

  port_endpoint #(.PORT_SIZE(PS), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .port_o   (port_o),
    .port_i   (port_i),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
`ifdef LINK_STATS_EN
    ,
    .tx_count (tx_count),
    .rx_count (rx_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    loopback = 1'b0; peer_o = '0;
    step(); step();
    checks++;
    if (port_o !== '0) begin
      errors++; $display("FAIL reset_port_o got=%h want=0", port_o);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid);
    end
    peer_o[PS-2] = 1'b1; #1;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_tx_ready_hi got=%b want=1", tx_ready);
    end
    peer_o[PS-2] = 1'b0; #1;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL reset_tx_ready_lo got=%b want=0", tx_ready);
    end
    rst = 1'b0;
    step();
    checks++;
    if (port_o[PS-1:PS-2] !== 2'b01) begin
      errors++; $display("FAIL post_reset_link got=%b want=01", port_o[PS-1:PS-2]);
    end
  endtask

  task automatic test_loopback();
    logic exp_v;
    loopback = 1'b1; rx_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        tx_valid = 1'b1; tx_data = DS'(k + 1);
        #1;
        checks++;
        if (tx_ready !== 1'b1) begin
          errors++; $display("FAIL loop_tx_ready k=%0d got=%b want=1", k, tx_ready);
        end
      end else begin
        tx_valid = 1'b0;
      end
      step();
      exp_v = (k >= 1) && (k <= 8);
      checks++;
      if (rx_valid !== exp_v) begin
        errors++; $display("FAIL loop_rx_valid k=%0d got=%b want=%b", k, rx_valid, exp_v);
      end else if (exp_v) begin
        checks++;
        if (rx_data !== DS'(k)) begin
          errors++; $display("FAIL loop_rx_data k=%0d got=%h want=%h", k, rx_data, DS'(k));
        end
      end
    end
    checks++;
    if (port_o[PS-1] !== 1'b0) begin
      errors++; $display("FAIL loop_idle_valid got=%b want=0", port_o[PS-1]);
    end
    loopback = 1'b0; rx_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int   idx;
    logic dr;
    logic pv;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      dr = port_o[PS-2];
      pv = (idx < 6);
      peer_o = {pv, 1'b1, DS'(37'h100 + idx)};
      step();
      if (pv && dr) idx++;
    end
    checks++;
    if (idx !== 4) begin
      errors++; $display("FAIL bp_accepted got=%0d want=4", idx);
    end
    checks++;
    if (port_o[PS-2] !== 1'b0) begin
      errors++; $display("FAIL bp_ready_full got=%b want=0", port_o[PS-2]);
    end
    checks++;
    if (rx_data !== 37'h100) begin
      errors++; $display("FAIL bp_head got=%h want=100", rx_data);
    end
    // one pop pulse; peer still offers packet 5
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    checks++;
    if (port_o[PS-2] !== 1'b1 || rx_data !== 37'h101) begin
      errors++; $display("FAIL bp_after_pop ready=%b head=%h want ready=1 head=101", port_o[PS-2], rx_data);
    end
    dr = port_o[PS-2];
    step();
    if (dr) idx++;
    peer_o = '0;
    checks++;
    if (port_o[PS-2] !== 1'b0 || idx !== 5) begin
      errors++; $display("FAIL bp_refill ready=%b idx=%0d want ready=0 idx=5", port_o[PS-2], idx);
    end
    rx_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== DS'(37'h100 + j)) begin
        errors++; $display("FAIL bp_drain j=%0d valid=%b data=%h want data=%h", j, rx_valid, rx_data, DS'(37'h100 + j));
      end
      step();
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty got=%b want=0", rx_valid);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_tx_stall();
    int n1;
    n1 = 0;
    peer_o = '0;
    tx_valid = 1'b1; tx_data = 37'h1_2345_6789;
    #1;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL stall_first_ready got=%b want=1", tx_ready);
    end
    step();
    tx_data = 37'h0_0BAD_F00D;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (tx_ready !== 1'b0 || port_o[PS-1] !== 1'b1 || port_o[DS-1:0] !== 37'h1_2345_6789) begin
        errors++; $display("FAIL stall_hold c=%0d tx_ready=%b valid=%b pkt=%h want 0/1/123456789", c, tx_ready, port_o[PS-1], port_o[DS-1:0]);
      end
      step();
    end
    peer_o[PS-2] = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready got=%b want=1", tx_ready);
    end
    for (int c = 0; c < 3; c++) begin
      if (port_o[PS-1] && peer_o[PS-2] && port_o[DS-1:0] == 37'h1_2345_6789) n1++;
      tx_valid = (c == 0);
      step();
      if (c == 0) begin
        checks++;
        if (port_o[PS-1] !== 1'b1 || port_o[DS-1:0] !== 37'h0_0BAD_F00D) begin
          errors++; $display("FAIL stall_next_pkt valid=%b pkt=%h want 1/00badf00d", port_o[PS-1], port_o[DS-1:0]);
        end
      end
    end
    tx_valid = 1'b0;
    checks++;
    if (n1 !== 1) begin
      errors++; $display("FAIL stall_transfers got=%0d want=1", n1);
    end
    checks++;
    if (port_o[PS-1] !== 1'b0) begin
      errors++; $display("FAIL stall_idle got=%b want=0", port_o[PS-1]);
    end
    peer_o = '0;
  endtask

  task automatic test_wrap();
    logic [31:0] pat;
    int          idx;
    int          popped;
    int          cyc;
    logic        dr;
    logic        pv;
    pat = 32'hB53C_E29D;
    idx = 0; popped = 0; cyc = 0;
    while (popped < 20 && cyc < 300) begin
      dr = port_o[PS-2];
      pv = (idx < 20);
      peer_o = {pv, 1'b1, DS'(37'h200 + idx)};
      rx_ready = pat[cyc % 32];
      #1;
      if (rx_valid && rx_ready) begin
        checks++;
        if (rx_data !== DS'(37'h200 + popped)) begin
          errors++; $display("FAIL wrap_order n=%0d got=%h want=%h", popped, rx_data, DS'(37'h200 + popped));
        end
        popped++;
      end
      step();
      if (pv && dr) idx++;
      cyc++;
    end
    checks++;
    if (popped !== 20) begin
      errors++; $display("FAIL wrap_count got=%0d want=20", popped);
    end
    peer_o = '0; rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_extra got=%b want=0", rx_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      peer_o = {1'b1, 1'b0, DS'(37'h300 + c)};
      step();
    end
    peer_o = '0;
    tx_valid = 1'b1; tx_data = 37'h5A;
    step();
    tx_valid = 1'b0;
    checks++;
    if (rx_valid !== 1'b1 || port_o[PS-1] !== 1'b1) begin
      errors++; $display("FAIL mid_setup rx_valid=%b link_valid=%b want 1/1", rx_valid, port_o[PS-1]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (rx_valid !== 1'b0 || port_o !== '0) begin
      errors++; $display("FAIL mid_reset rx_valid=%b port_o=%h want 0/0", rx_valid, port_o);
    end
    step();
    checks++;
    if (port_o[PS-1:PS-2] !== 2'b01 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL mid_recover link=%b rx_valid=%b want 01/0", port_o[PS-1:PS-2], rx_valid);
    end
  endtask

`ifdef LINK_STATS_EN
  task automatic send_loop(input int n);
    loopback = 1'b1; rx_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      tx_valid = 1'b1; tx_data = DS'(k);
      step();
    end
    tx_valid = 1'b0;
    step(); step();
    loopback = 1'b0; rx_ready = 1'b0;
  endtask

  task automatic test_stats();
    checks++;
    if (tx_count !== 16'd0 || rx_count !== 16'd0) begin
      errors++; $display("FAIL stats_zero tx=%0d rx=%0d want 0/0", tx_count, rx_count);
    end
    send_loop(10);
    checks++;
    if (tx_count !== 16'd10 || rx_count !== 16'd10) begin
      errors++; $display("FAIL stats_ten tx=%0d rx=%0d want 10/10", tx_count, rx_count);
    end
    force dut.tx_cnt_q = 16'hFFFE;
    force dut.rx_cnt_q = 16'hFFFE;
    step();
    release dut.tx_cnt_q;
    release dut.rx_cnt_q;
    send_loop(3);
    checks++;
    if (tx_count !== 16'hFFFF || rx_count !== 16'hFFFF) begin
      errors++; $display("FAIL stats_sat tx=%h rx=%h want ffff/ffff", tx_count, rx_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_backpressure();
    test_tx_stall();
    test_wrap();
    test_reset_mid();
`ifdef LINK_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
